// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Also provides a default for the global DATA_WIDTH macro.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mdu_pkg;

  localparam int XLEN           = `DATA_WIDTH;
  localparam int MDU_ITERATIONS = 32;
  localparam int CNT_W          = 6;

  localparam logic [XLEN-1:0] QUOT_ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration of the MDU datapath: shift-add multiply step, and
// (with MDU_DIV_EN defined) a restoring-division step producing one quotient bit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mdu_iter_core
  import mdu_pkg::*;
(
`ifdef MDU_DIV_EN
  input  logic              is_div,
`endif
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [4:0]        step,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] addend;
`ifdef MDU_DIV_EN
  logic [XLEN:0]     rem_shift;
  logic              ge;
  logic [XLEN-1:0]   rem_new;
`endif

  always_comb begin
    addend = '0;
    if (op_b[step]) begin
      addend = {{XLEN{1'b0}}, op_a} << step;
    end
    acc_next = acc + addend;
`ifdef MDU_DIV_EN
    // Upper word holds the partial remainder, lower word collects quotient bits
    rem_shift = {acc[2*XLEN-1:XLEN], op_a[5'(XLEN-1) - step]};
    ge        = (rem_shift >= {1'b0, op_b});
    rem_new   = ge ? (rem_shift[XLEN-1:0] - op_b) : rem_shift[XLEN-1:0];
    if (is_div) begin
      acc_next = {rem_new, acc[XLEN-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with fixed 35-cycle latency.
// Define MDU_DIV_EN to include the divide datapath; otherwise divide ops return 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mul_div_unit
  import mdu_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   Kill,
  input  logic [2:0]             Op,
  input  logic [`DATA_WIDTH-1:0] OperandA,
  input  logic [`DATA_WIDTH-1:0] OperandB,
  output logic                   Busy,
  output logic                   Done,
  output logic [`DATA_WIDTH-1:0] Result
);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   fix_val;

  assign sign_a = a_q[XLEN-1] && (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sign_b = b_q[XLEN-1] && (op_q inside {OP_MULH, OP_DIV, OP_REM});
  assign prod   = neg_res_q ? -acc_q : acc_q;

  mdu_iter_core u_iter (
`ifdef MDU_DIV_EN
    .is_div   (op_q[2]),
`endif
    .acc      (acc_q),
    .op_a     (a_q),
    .op_b     (b_q),
    .step     (cnt_q[CNT_W-2:0]),
    .acc_next (acc_step)
  );

  // Negating the whole accumulator also yields the correctly signed quotient in the low word
  always_comb begin
    fix_val = '0;
    if (!op_q[2]) begin
      fix_val = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`ifdef MDU_DIV_EN
    else if (op_q == OP_DIV || op_q == OP_DIVU) begin
      if (b_q == '0) begin
        fix_val = QUOT_ALL_ONES;
      end else if (op_q == OP_DIV && neg_res_q && a_q == INT_MIN && b_q == XLEN'(1)) begin
        fix_val = INT_MIN;
      end else begin
        fix_val = prod[XLEN-1:0];
      end
    end else begin
      fix_val = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Kill) begin
          op_d    = mdu_op_e'(Op);
          a_d     = OperandA;
          b_d     = OperandB;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        a_d       = sign_a ? -a_q : a_q;
        b_d       = sign_b ? -b_q : b_q;
        neg_res_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        cnt_d     = '0;
        acc_d     = '0;
        state_d   = S_CALC;
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MDU_ITERATIONS - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush abandons the operation without touching the previous result
    if (Kill && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign Busy   = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign Done   = (state_q == S_DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divide expectations follow MDU_DIV_EN.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        Kill = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int assertion_count = 0;
  int fail_count = 0;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mul_div_unit dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Kill     (Kill),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] divExp(input logic [31:0] v);
    return DIV_EN ? v : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertion_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Launch one op, optionally poke Start mid-flight, then check latency, busy span and result
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int inject_at);
    int cyc;
    int busy_cycles;
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
    cyc = 1;
    busy_cycles = 0;
    while (!Done && cyc < 100) begin
      if (Busy) busy_cycles++;
      if (cyc == inject_at) begin
        Start = 1'b1; Op = OP_MULHU; OperandA = '1; OperandB = '1;
      end
      @(negedge Clk);
      Start = 1'b0;
      cyc++;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'd35);
    checkOutput({tag, " busy_span"}, 64'(busy_cycles), 64'd34);
    checkOutput({tag, " busy_in_done"}, 64'(Busy), 64'd0);
    checkOutput({tag, " result"}, 64'(Result), 64'(exp_res));
    @(negedge Clk);
    checkOutput({tag, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    @(negedge Clk);
    checkOutput("reset busy", 64'(Busy), 64'd0);
    checkOutput("reset done", 64'(Done), 64'd0);
    checkOutput("reset result", 64'(Result), 64'd0);
    Rst = 1'b0;

    @(negedge Clk);
    Start = 1'b1; Kill = 1'b1; Op = OP_MUL; OperandA = 32'd3; OperandB = 32'd3;
    @(negedge Clk);
    Start = 1'b0; Kill = 1'b0;
    checkOutput("kill_start_idle busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    checkOutput("kill_start_idle busy2", 64'(Busy), 64'd0);

    applyStimulus("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    applyStimulus("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    applyStimulus("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    applyStimulus("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    applyStimulus("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, divExp(32'hFFFF_FFFD), 0);
    applyStimulus("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, divExp(32'hFFFF_FFFF), 0);
    applyStimulus("divu", OP_DIVU, 32'd100, 32'd7, divExp(32'd14), 0);
    applyStimulus("remu", OP_REMU, 32'd100, 32'd7, divExp(32'd2), 0);
    applyStimulus("div_by_zero", OP_DIV, 32'd5, 32'd0, divExp(32'hFFFF_FFFF), 0);
    applyStimulus("rem_by_zero", OP_REM, 32'd5, 32'd0, divExp(32'd5), 0);
    applyStimulus("div_neg_by_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, divExp(32'hFFFF_FFFF), 0);
    applyStimulus("rem_neg_by_zero", OP_REM, 32'hFFFF_FFFB, 32'd0, divExp(32'hFFFF_FFFB), 0);
    applyStimulus("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, divExp(32'h8000_0000), 0);
    applyStimulus("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    applyStimulus("start_mid_calc", OP_MUL, 32'd2, 32'd3, 32'd6, 5);
    applyStimulus("mul_pre_kill", OP_MUL, 32'd3, 32'd5, 32'd15, 0);

    @(negedge Clk);
    Start = 1'b1; Op = OP_MUL; OperandA = 32'd6; OperandB = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    checkOutput("kill pre_busy", 64'(Busy), 64'd1);
    Kill = 1'b1;
    @(negedge Clk);
    Kill = 1'b0;
    checkOutput("kill busy_low", 64'(Busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) saw_done = 1'b1;
    end
    checkOutput("kill no_done", 64'(saw_done), 64'd0);
    checkOutput("kill result_held", 64'(Result), 64'd15);
    applyStimulus("mul_after_kill", OP_MUL, 32'd6, 32'd7, 32'd42, 0);

    @(negedge Clk);
    Start = 1'b1; Op = OP_MUL; OperandA = 32'd9; OperandB = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    checkOutput("rst pre_busy", 64'(Busy), 64'd1);
    #2 Rst = 1'b1;
    #1;
    checkOutput("rst async busy", 64'(Busy), 64'd0);
    checkOutput("rst async done", 64'(Done), 64'd0);
    checkOutput("rst async result", 64'(Result), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    applyStimulus("divu_after_rst", OP_DIVU, 32'd100, 32'd7, divExp(32'd14), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
    $finish;
  end

endmodule
